// File: rtl/cmd_fetch_pkg.sv
// Shared constants, FSM encoding and command-word sequencing for the command fetcher.
package cmd_fetch_pkg;

  localparam int unsigned CMD_WORDS        = 4;
  localparam logic [31:0] CMD_BASE_DEFAULT = 32'h0000_0000;
  localparam int unsigned MAX_CMDS_DEFAULT = 32;

  localparam logic [1:0] W_OP_STRIDE = 2'd0;
  localparam logic [1:0] W_CH_SIZE   = 2'd1;
  localparam logic [1:0] W_RD_ADDR   = 2'd2;
  localparam logic [1:0] W_WB_ADDR   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Word order inside one command; the write-back address wraps to the next op word.
  function automatic logic [1:0] next_word(input logic [1:0] w);
    logic [1:0] n;
    case (w)
      W_OP_STRIDE: n = W_CH_SIZE;
      W_CH_SIZE:   n = W_RD_ADDR;
      W_RD_ADDR:   n = W_WB_ADDR;
      default:     n = W_OP_STRIDE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cmd_fetch_fifo.sv
// Show-ahead synchronous FIFO: rdata always shows the oldest entry, pop just advances.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // NOTE: combinational next-state uses blocking '=' with every output defaulted first,
  // which rules out latches; only the always_ff blocks below use '<='.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define validity,
  // and the consumer masks rdata while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cmd_fetch.sv
// Streams a list of 4-word commands from SDRAM into a prefetch FIFO for the sequencer,
// issuing reads only while buffer space is guaranteed for every outstanding response.
module cmd_fetch
  import cmd_fetch_pkg::*;
#(
  parameter logic [31:0] CMD_BASE   = CMD_BASE_DEFAULT,
  parameter int unsigned MAX_CMDS   = MAX_CMDS_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  cmd_size,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] cmd,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_last,
  output logic        cmd_fifo_empty,
  output logic        busy,
  output logic        done,
  output logic        cfg_err
);

  localparam int unsigned CNT_W = $clog2(MAX_CMDS + 1);
  localparam int unsigned WI_W  = CNT_W + 2;
  localparam int unsigned FW    = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cmd_total_q, cmd_total_d;
  logic [WI_W-1:0]   words_issued_q, words_issued_d;
  logic [FW-1:0]     outstanding_q, outstanding_d;
  logic [1:0]        out_word_q, out_word_d;
  logic              mem_re_q, mem_re_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;

  logic [FW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [31:0]       fifo_rdata;
  logic              fifo_push, fifo_pop, accepted, oversize;
  logic [WI_W-1:0]   total_words;
  logic [FW:0]       inflight;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (mem_rdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    accepted    = mem_re_q && mem_gnt;
    fifo_push   = mem_rvalid && (state_q == ST_FETCH || state_q == ST_DRAIN) && (outstanding_q != '0);
    fifo_pop    = !fifo_empty && cmd_ready;
    total_words = WI_W'(cmd_total_q) * WI_W'(CMD_WORDS);
    oversize    = 32'(cmd_size) > MAX_CMDS;
    // Upper bound on buffer occupancy next cycle; a pop this cycle is ignored on purpose.
    inflight    = {1'b0, fifo_count} + {1'b0, outstanding_q} + (FW+1)'(accepted);

    state_d        = state_q;
    cmd_total_d    = cmd_total_q;
    words_issued_d = words_issued_q + WI_W'(accepted);
    outstanding_d  = outstanding_q + FW'(accepted) - FW'(fifo_push);
    out_word_d     = fifo_pop ? next_word(out_word_q) : out_word_q;
    mem_re_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    done_d         = 1'b0;
    cfg_err_d      = cfg_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_err_d      = oversize;
          cmd_total_d    = oversize ? CNT_W'(MAX_CMDS) : CNT_W'(cmd_size);
          words_issued_d = '0;
          outstanding_d  = '0;
          out_word_d     = W_OP_STRIDE;
          if (cmd_size == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (words_issued_d == total_words) begin
          state_d = ST_DRAIN;
        end else if ((mem_re_q && !mem_gnt) || (inflight < (FW+1)'(FIFO_DEPTH))) begin
          mem_re_d   = 1'b1;
          mem_addr_d = CMD_BASE + 32'(words_issued_d);
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && outstanding_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cmd_total_q    <= '0;
      words_issued_q <= '0;
      outstanding_q  <= '0;
      out_word_q     <= W_OP_STRIDE;
      mem_re_q       <= 1'b0;
      mem_addr_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_total_q    <= cmd_total_d;
      words_issued_q <= words_issued_d;
      outstanding_q  <= outstanding_d;
      out_word_q     <= out_word_d;
      mem_re_q       <= mem_re_d;
      mem_addr_q     <= mem_addr_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

  assign mem_re         = mem_re_q;
  assign mem_addr       = mem_addr_q;
  assign cmd            = fifo_empty ? '0 : fifo_rdata;
  assign cmd_valid      = !fifo_empty;
  assign cmd_last       = !fifo_empty && (out_word_q == W_WB_ADDR);
  assign cmd_fifo_empty = fifo_empty && (state_q == ST_IDLE || state_q == ST_DONE ||
                                         (state_q == ST_DRAIN && outstanding_q == '0));
  assign busy           = busy_q;
  assign done           = done_q;
  assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_cmd_fetch.sv
// Scoreboard bench for cmd_fetch: a latency-modelled SDRAM responder plus per-scenario tasks.
module tb_cmd_fetch;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [6:0]  cmd_size;
  logic        mem_re, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_rdata = '0, cmd;
  logic        cmd_valid, cmd_ready = 1'b1, cmd_last, cmd_fifo_empty, busy, done, cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cmd_fetch #(.CMD_BASE(32'h0), .MAX_CMDS(32), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_size(cmd_size),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_last(cmd_last),
    .cmd_fifo_empty(cmd_fifo_empty), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct { int due; logic [31:0] addr; } rd_t;

  // Scenario knobs, written only by the test tasks.
  int       lat = 3, ready_mode = 1;
  bit       lat_rand = 0, gnt_rand = 0, chk_en = 0;
  logic [7:0] tag = 8'h00;

  logic [31:0] exp_addr[$];
  logic [32:0] exp_cmd[$];
  rd_t         pend[$];

  // Event counters, written only by the responder/monitor.
  int cyc = 0, reads_cnt = 0, rvalid_cnt = 0, xfer_cnt = 0, last_cnt = 0;
  int done_cnt = 0, busy_cnt = 0, valid_cnt = 0, hold_cnt = 0;

  logic        re_prev = 0, gnt_prev = 0, rst_prev = 0, valid_prev = 0, ready_prev = 0;
  logic        last_prev = 0, rv_prev = 0, busy_prev = 0;
  logic [31:0] addr_prev = '0, cmd_prev = '0;

  function automatic logic [31:0] mem_word(input logic [7:0] t, input logic [31:0] a);
    return {t, 8'h00, a[15:0]};
  endfunction

  // SDRAM responder and output monitor; everything happens on the falling edge.
  always @(negedge clk) begin
    rd_t         r;
    logic [31:0] ea;
    logic [32:0] ec;
    cyc++;
    if (re_prev && gnt_prev) begin
      reads_cnt++;
      r.due  = cyc + (lat_rand ? int'($urandom_range(1, 5)) : lat) - 1;
      r.addr = addr_prev;
      pend.push_back(r);
      if (chk_en) begin
        n_checks++;
        if (exp_addr.size() == 0) begin
          n_fail++;
          $display("FAIL read_addr: read of %h issued, no read expected", addr_prev);
        end else begin
          ea = exp_addr.pop_front();
          if (addr_prev !== ea) begin
            n_fail++;
            $display("FAIL read_addr: got %h, expected %h", addr_prev, ea);
          end
        end
      end
    end
    if (chk_en && rst_prev && re_prev && !gnt_prev) begin
      hold_cnt++;
      n_checks++;
      if (mem_re !== 1'b1 || mem_addr !== addr_prev) begin
        n_fail++;
        $display("FAIL req_hold: mem_re=%b addr=%h, expected 1 and %h", mem_re, mem_addr, addr_prev);
      end
    end
    if (chk_en && rst_prev && valid_prev && !ready_prev) begin
      n_checks++;
      if ({cmd_valid, cmd_last, cmd} !== {1'b1, last_prev, cmd_prev}) begin
        n_fail++;
        $display("FAIL cmd_hold: got v=%b l=%b %h, expected v=1 l=%b %h",
                 cmd_valid, cmd_last, cmd, last_prev, cmd_prev);
      end
    end
    if (chk_en && rst_prev && busy_prev && rv_prev && !valid_prev) begin
      n_checks++;
      if (cmd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL first_word_latency: cmd_valid=%b one cycle after rvalid, expected 1", cmd_valid);
      end
    end

    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(tag, r.addr);
      rvalid_cnt++;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    mem_gnt   = mem_re && (!gnt_rand || $urandom_range(0, 1) == 1);
    cmd_ready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 1) == 1);

    if (cmd_valid === 1'b1) valid_cnt++;
    if (done === 1'b1)      done_cnt++;
    if (busy === 1'b1)      busy_cnt++;
    if (rst_n && cmd_valid === 1'b1 && cmd_ready) begin
      xfer_cnt++;
      if (cmd_last) last_cnt++;
      if (chk_en) begin
        n_checks++;
        if (exp_cmd.size() == 0) begin
          n_fail++;
          $display("FAIL cmd_word: got l=%b %h, no word expected", cmd_last, cmd);
        end else begin
          ec = exp_cmd.pop_front();
          if ({cmd_last, cmd} !== ec) begin
            n_fail++;
            $display("FAIL cmd_word: got l=%b %h, expected l=%b %h", cmd_last, cmd, ec[32], ec[31:0]);
          end
        end
      end
    end

    re_prev = mem_re;  addr_prev = mem_addr; gnt_prev = mem_gnt; rst_prev = rst_n;
    valid_prev = cmd_valid; ready_prev = cmd_ready; last_prev = cmd_last; cmd_prev = cmd;
    rv_prev = mem_rvalid; busy_prev = busy;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_list(input int n, input bit expect_it);
    int   tot;
    logic l;
    tot = (n > 32) ? 32 : n;
    if (expect_it) begin
      for (int a = 0; a < 4 * tot; a++) begin
        l = (a % 4 == 3);
        exp_addr.push_back(32'(a));
        exp_cmd.push_back({l, mem_word(tag, 32'(a))});
      end
    end
    start    = 1'b1;
    cmd_size = 7'(n);
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int base = done_cnt;
    int k = 0;
    while (done_cnt == base && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (done_cnt == base) begin
      n_fail++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
    end
    tick(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cmd_size = '0;
    tick(3);
    n_checks++;
    if ({mem_re, mem_addr, cmd, cmd_valid, cmd_last, cmd_fifo_empty, busy, done, cfg_err} !==
        {1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: re=%b addr=%h cmd=%h v=%b l=%b fe=%b busy=%b done=%b err=%b",
               mem_re, mem_addr, cmd, cmd_valid, cmd_last, cmd_fifo_empty, busy, done, cfg_err);
    end
    rst_n = 1'b1;
    tick(2);
    n_checks++;
    if ({mem_re, busy, cmd_valid, cmd_fifo_empty} !== 4'b0001) begin
      n_fail++;
      $display("FAIL idle_after_reset: re=%b busy=%b v=%b fe=%b, expected 0 0 0 1",
               mem_re, busy, cmd_valid, cmd_fifo_empty);
    end
  endtask

  task automatic test_single();
    int r0 = reads_cnt, x0 = xfer_cnt, l0 = last_cnt, d0 = done_cnt;
    tag = 8'h11; lat = 3; lat_rand = 0; gnt_rand = 0; ready_mode = 1; chk_en = 1;
    start_list(1, 1);
    wait_done("single", 200);
    n_checks++;
    if (reads_cnt - r0 != 4 || xfer_cnt - x0 != 4 || last_cnt - l0 != 1 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL single_counts: reads=%0d xfers=%0d lasts=%0d dones=%0d, expected 4 4 1 1",
               reads_cnt - r0, xfer_cnt - x0, last_cnt - l0, done_cnt - d0);
    end
    n_checks++;
    if ({cmd_fifo_empty, busy} !== 2'b10 || exp_cmd.size() != 0) begin
      n_fail++;
      $display("FAIL single_end: fe=%b busy=%b pending=%0d, expected 1 0 0",
               cmd_fifo_empty, busy, exp_cmd.size());
    end
  endtask

  task automatic test_backpressure();
    int r0 = reads_cnt, x0 = xfer_cnt;
    tag = 8'h22; lat = 3; ready_mode = 0;
    start_list(4, 1);
    tick(20);
    n_checks++;
    if (mem_re !== 1'b0 || reads_cnt - r0 != 8) begin
      n_fail++;
      $display("FAIL bp_credit: mem_re=%b reads=%0d, expected 0 and 8", mem_re, reads_cnt - r0);
    end
    n_checks++;
    if ({cmd_valid, cmd_last, cmd} !== {1'b1, 1'b0, mem_word(8'h22, 32'd0)}) begin
      n_fail++;
      $display("FAIL bp_head: v=%b l=%b cmd=%h, expected 1 0 %h",
               cmd_valid, cmd_last, cmd, mem_word(8'h22, 32'd0));
    end
    ready_mode = 1;
    wait_done("backpressure", 300);
    n_checks++;
    if (xfer_cnt - x0 != 16 || reads_cnt - r0 != 16 || exp_cmd.size() != 0) begin
      n_fail++;
      $display("FAIL bp_total: xfers=%0d reads=%0d pending=%0d, expected 16 16 0",
               xfer_cnt - x0, reads_cnt - r0, exp_cmd.size());
    end
  endtask

  task automatic test_oversize();
    int r0 = reads_cnt, x0 = xfer_cnt, l0 = last_cnt;
    tag = 8'h33; lat = 2; ready_mode = 2;
    start_list(40, 1);
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize_cfg_err: got %b, expected 1", cfg_err);
    end
    wait_done("oversize", 3000);
    n_checks++;
    if (reads_cnt - r0 != 128 || xfer_cnt - x0 != 128 || last_cnt - l0 != 32 || cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize_total: reads=%0d xfers=%0d lasts=%0d err=%b, expected 128 128 32 1",
               reads_cnt - r0, xfer_cnt - x0, last_cnt - l0, cfg_err);
    end
  endtask

  task automatic test_zero();
    int r0 = reads_cnt, b0 = busy_cnt, d0 = done_cnt;
    tag = 8'h44; ready_mode = 1;
    start_list(0, 0);
    n_checks++;
    if ({done, busy, cfg_err} !== 3'b110) begin
      n_fail++;
      $display("FAIL zero_pulse: done=%b busy=%b err=%b, expected 1 1 0", done, busy, cfg_err);
    end
    tick();
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL zero_after: done=%b busy=%b, expected 0 0", done, busy);
    end
    tick(2);
    n_checks++;
    if (reads_cnt != r0 || busy_cnt - b0 != 1 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL zero_counts: reads=%0d busy_cycles=%0d dones=%0d, expected 0 1 1",
               reads_cnt - r0, busy_cnt - b0, done_cnt - d0);
    end
  endtask

  task automatic test_stall_overlap();
    int r0 = reads_cnt, x0 = xfer_cnt, d0 = done_cnt, h0 = hold_cnt;
    tag = 8'h55; gnt_rand = 1; lat_rand = 1; ready_mode = 2;
    start_list(3, 1);
    tick(3);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL overlap_busy: busy=%b before second start, expected 1", busy);
    end
    start_list(5, 0);
    wait_done("stall", 1000);
    n_checks++;
    if (reads_cnt - r0 != 12 || xfer_cnt - x0 != 12 || done_cnt - d0 != 1 || exp_cmd.size() != 0) begin
      n_fail++;
      $display("FAIL overlap_total: reads=%0d xfers=%0d dones=%0d pending=%0d, expected 12 12 1 0",
               reads_cnt - r0, xfer_cnt - x0, done_cnt - d0, exp_cmd.size());
    end
    n_checks++;
    if (hold_cnt - h0 == 0) begin
      n_fail++;
      $display("FAIL stall_seen: withheld grants=%0d, expected at least 1", hold_cnt - h0);
    end
    gnt_rand = 0; lat_rand = 0;
  endtask

  task automatic test_reset_mid();
    int x0 = xfer_cnt, k = 0, vc, rv0;
    tag = 8'h66; lat = 4; ready_mode = 1;
    start_list(4, 1);
    while (xfer_cnt - x0 < 5 && k < 200) begin
      tick();
      k++;
    end
    n_checks++;
    if (xfer_cnt - x0 < 5 || pend.size() < 2) begin
      n_fail++;
      $display("FAIL mid_setup: xfers=%0d outstanding=%0d, expected 5 and >=2", xfer_cnt - x0, pend.size());
    end
    chk_en = 0;
    rst_n  = 1'b0;
    exp_addr.delete();
    exp_cmd.delete();
    tick();
    rv0 = rvalid_cnt;
    vc  = valid_cnt;
    n_checks++;
    if ({mem_re, mem_addr, cmd, cmd_valid, cmd_last, cmd_fifo_empty, busy, done, cfg_err} !==
        {1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: re=%b addr=%h cmd=%h v=%b l=%b fe=%b busy=%b done=%b",
               mem_re, mem_addr, cmd, cmd_valid, cmd_last, cmd_fifo_empty, busy, done);
    end
    tick(2);
    rst_n = 1'b1;
    tick(12);
    n_checks++;
    if (valid_cnt != vc || rvalid_cnt == rv0 || busy !== 1'b0 || cmd_fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_late_data: valid_cycles=%0d late_rvalids=%0d busy=%b fe=%b, expected 0 >0 0 1",
               valid_cnt - vc, rvalid_cnt - rv0, busy, cmd_fifo_empty);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cmd_size = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_oversize();
    test_zero();
    test_stall_overlap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
